cneuron_pipe: RTL and testbench

Parametrised, pipelined successor to the 2x2 CNeuron. Computes a signed dot product of NUM_TAPS pixels against a loadable kernel, with optional arithmetic right shift and ReLU, and saturates the result to OUT_W bits. Uses valid/ready streaming handshakes on input and output, so it can sit between a line-buffer window generator and a feature-map writer.

---
 rtl/cneuron_pkg.sv | 31 +++
 rtl/cneuron_adder_tree.sv | 27 ++
 rtl/cneuron_pipe.sv | 135 +++++++++++++
 tb/tb_cneuron_pipe.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cneuron_pkg.sv
// Shared sizing helpers and saturation arithmetic for the pipelined conv neuron.
package cneuron_pkg;

    localparam int DEFAULT_NUM_TAPS = 4;
    localparam int DEFAULT_DATA_W   = 8;
    localparam int DEFAULT_OUT_W    = 8;
    localparam int DEFAULT_SHIFT    = 0;

    // Width of the saturation datapath; holds any ACC_W this block is built for.
    localparam int SAT_CALC_W = 64;

    function automatic int acc_width(input int data_w, input int taps);
        return 2 * data_w + $clog2(taps);
    endfunction

    // Returns {sat, result}; result is clipped to the signed out_w range.
    function automatic logic [SAT_CALC_W:0] sat_signed(input logic signed [SAT_CALC_W-1:0] value,
                                                       input int out_w);
        logic signed [SAT_CALC_W-1:0] max_v;
        logic signed [SAT_CALC_W-1:0] min_v;
        max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (out_w - 1));
        if (value > max_v) begin
            return {1'b1, max_v};
        end else if (value < min_v) begin
            return {1'b1, min_v};
        end
        return {1'b0, value};
    endfunction

endpackage

// File: rtl/cneuron_adder_tree.sv
// Combinational signed sum of a packed product vector, sign-extended to SUM_W.
module cneuron_adder_tree #(
    parameter int NUM_TAPS = 4,
    parameter int IN_W     = 16,
    parameter int SUM_W    = 18
) (
    input  logic [NUM_TAPS*IN_W-1:0] prod_vec,
    output logic signed [SUM_W-1:0]  sum
);

    logic signed [SUM_W-1:0] ext [NUM_TAPS];

    generate
        for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_ext
            assign ext[gi] = {{(SUM_W-IN_W){prod_vec[gi*IN_W+IN_W-1]}},
                              prod_vec[gi*IN_W +: IN_W]};
        end
    endgenerate

    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_TAPS; i++) begin
            sum = sum + ext[i];
        end
    end

endmodule

// File: rtl/cneuron_pipe.sv
// Three-stage streaming dot product (multiply, sum, shift/ReLU/saturate) with
// a single global stall enable driven by the output handshake.
module cneuron_pipe
    import cneuron_pkg::*;
#(
    parameter int NUM_TAPS = DEFAULT_NUM_TAPS,
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int OUT_W    = DEFAULT_OUT_W,
    parameter int SHIFT    = DEFAULT_SHIFT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       kernel_load,
    input  logic [NUM_TAPS*DATA_W-1:0] kernel_in,
    input  logic                       relu_en,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_TAPS*DATA_W-1:0] pixels,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           conv_result,
    output logic                       sat
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int ACC_W  = acc_width(DATA_W, NUM_TAPS);

    logic                        en;
    logic [NUM_TAPS*DATA_W-1:0]  kernel_q, kernel_d;
    logic [NUM_TAPS*PROD_W-1:0]  prod;
    logic [NUM_TAPS*PROD_W-1:0]  s1_prod_q, s1_prod_d;
    logic                        s1_valid_q, s1_valid_d;
    logic                        s1_relu_q, s1_relu_d;
    logic signed [ACC_W-1:0]     tree_sum;
    logic signed [ACC_W-1:0]     s2_sum_q, s2_sum_d;
    logic                        s2_valid_q, s2_valid_d;
    logic                        s2_relu_q, s2_relu_d;
    logic signed [ACC_W-1:0]     shifted;
    logic signed [ACC_W-1:0]     relu_val;
    logic [SAT_CALC_W:0]         sat_word;
    logic                        out_valid_q, out_valid_d;
    logic [OUT_W-1:0]            conv_result_q, conv_result_d;
    logic                        sat_q, sat_d;
    logic                        unused_sat_bits;

    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;

    // Products use the kernel as registered before this edge, so a beat
    // accepted alongside kernel_load still sees the old weights.
    generate
        for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_mul
            assign prod[gi*PROD_W +: PROD_W] =
                $signed(pixels[gi*DATA_W +: DATA_W]) * $signed(kernel_q[gi*DATA_W +: DATA_W]);
        end
    endgenerate

    cneuron_adder_tree #(
        .NUM_TAPS (NUM_TAPS),
        .IN_W     (PROD_W),
        .SUM_W    (ACC_W)
    ) u_tree (
        .prod_vec (s1_prod_q),
        .sum      (tree_sum)
    );

    always_comb begin
        shifted  = s2_sum_q >>> SHIFT;
        relu_val = (s2_relu_q && shifted[ACC_W-1]) ? '0 : shifted;
        sat_word = sat_signed({{(SAT_CALC_W-ACC_W){relu_val[ACC_W-1]}}, relu_val}, OUT_W);
    end

    assign unused_sat_bits = &{1'b0, sat_word[SAT_CALC_W-1:OUT_W]};

    always_comb begin
        kernel_d      = kernel_load ? kernel_in : kernel_q;
        s1_valid_d    = s1_valid_q;
        s1_relu_d     = s1_relu_q;
        s1_prod_d     = s1_prod_q;
        s2_valid_d    = s2_valid_q;
        s2_relu_d     = s2_relu_q;
        s2_sum_d      = s2_sum_q;
        out_valid_d   = out_valid_q;
        conv_result_d = conv_result_q;
        sat_d         = sat_q;
        if (en) begin
            s1_valid_d  = in_valid;
            s2_valid_d  = s1_valid_q;
            out_valid_d = s2_valid_q;
            if (in_valid) begin
                s1_prod_d = prod;
                s1_relu_d = relu_en;
            end
            if (s1_valid_q) begin
                s2_sum_d  = tree_sum;
                s2_relu_d = s1_relu_q;
            end
            if (s2_valid_q) begin
                conv_result_d = sat_word[OUT_W-1:0];
                sat_d         = sat_word[SAT_CALC_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            kernel_q      <= '0;
            s1_valid_q    <= 1'b0;
            s1_relu_q     <= 1'b0;
            s1_prod_q     <= '0;
            s2_valid_q    <= 1'b0;
            s2_relu_q     <= 1'b0;
            s2_sum_q      <= '0;
            out_valid_q   <= 1'b0;
            conv_result_q <= '0;
            sat_q         <= 1'b0;
        end else begin
            kernel_q      <= kernel_d;
            s1_valid_q    <= s1_valid_d;
            s1_relu_q     <= s1_relu_d;
            s1_prod_q     <= s1_prod_d;
            s2_valid_q    <= s2_valid_d;
            s2_relu_q     <= s2_relu_d;
            s2_sum_q      <= s2_sum_d;
            out_valid_q   <= out_valid_d;
            conv_result_q <= conv_result_d;
            sat_q         <= sat_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign conv_result = conv_result_q;
    assign sat         = sat_q;

endmodule

// File: tb/tb_cneuron_pipe.sv
// Directed bench for cneuron_pipe: a SHIFT=0 and a SHIFT=1 instance share stimulus,
// and a monitor checks every consumed result against hand-computed values.
module tb_cneuron_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        kernel_load = 1'b0;
    logic [31:0] kernel_in = '0;
    logic        relu_en = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] pixels = '0;
    logic        out_ready = 1'b1;

    logic        in_ready, out_valid, sat;
    logic [7:0]  conv_result;
    logic        in_ready_sh, out_valid_sh, sat_sh;
    logic [7:0]  conv_result_sh;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] res;
        logic       sat;
        logic [7:0] res_sh;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    cneuron_pipe #(.NUM_TAPS(4), .DATA_W(8), .OUT_W(8), .SHIFT(0)) dut (
        .clk         (clk),
        .rst         (rst),
        .kernel_load (kernel_load),
        .kernel_in   (kernel_in),
        .relu_en     (relu_en),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .pixels      (pixels),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .conv_result (conv_result),
        .sat         (sat)
    );

    cneuron_pipe #(.NUM_TAPS(4), .DATA_W(8), .OUT_W(8), .SHIFT(1)) dut_sh (
        .clk         (clk),
        .rst         (rst),
        .kernel_load (kernel_load),
        .kernel_in   (kernel_in),
        .relu_en     (relu_en),
        .in_valid    (in_valid),
        .in_ready    (in_ready_sh),
        .pixels      (pixels),
        .out_valid   (out_valid_sh),
        .out_ready   (out_ready),
        .conv_result (conv_result_sh),
        .sat         (sat_sh)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    task automatic load_kernel(input logic [31:0] k);
        kernel_load = 1'b1;
        kernel_in   = k;
        @(posedge clk);
        #1;
        kernel_load = 1'b0;
    endtask

    // Drives one beat until accepted and queues its hand-computed result.
    task automatic send(input logic [31:0] pix, input logic relu, input logic kl,
                        input logic [31:0] kin, input logic [7:0] res, input logic s,
                        input logic [7:0] res_sh);
        int  n;
        logic acc;
        exp_t e;
        n   = 0;
        acc = 1'b0;
        in_valid    = 1'b1;
        pixels      = pix;
        relu_en     = relu;
        kernel_load = kl;
        kernel_in   = kl ? kin : kernel_in;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid    = 1'b0;
        kernel_load = 1'b0;
        check_eq("accept", {31'd0, acc}, 32'd1);
        e.res = res; e.sat = s; e.res_sh = res_sh;
        exp_q.push_back(e);
        $display("beat pix=%h relu=%0d kl=%0d -> expect %h sat=%0d shifted %h",
                 pix, relu, kl, res, s, res_sh);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_eq("drain", exp_q.size(), 32'd0);
    endtask

    // Output monitor: result order/values, stall stability and in_ready during stall.
    logic       held = 1'b0;
    logic [7:0] held_res = '0;
    logic       held_sat = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (out_valid && held) begin
                check_eq("hold_res", {24'd0, conv_result}, {24'd0, held_res});
                check_eq("hold_sat", {31'd0, sat}, {31'd0, held_sat});
            end
            if (out_valid && !out_ready) begin
                check_eq("in_ready_stall", {31'd0, in_ready}, 32'd0);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious", 32'd1, {31'd0, 1'b0});
                end else begin
                    e = exp_q.pop_front();
                    check_eq("res", {24'd0, conv_result}, {24'd0, e.res});
                    check_eq("sat", {31'd0, sat}, {31'd0, e.sat});
                    check_eq("res_sh", {24'd0, conv_result_sh}, {24'd0, e.res_sh});
                    $display("result %h sat=%0d shifted %h", conv_result, sat, conv_result_sh);
                end
            end
            held     <= out_valid && !out_ready;
            held_res <= conv_result;
            held_sat <= sat;
        end else begin
            held <= 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] pat;
        pat = 6'b101001;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_conv", {24'd0, conv_result}, 32'd0);
        check_eq("rst_sat", {31'd0, sat}, 32'd0);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Sign handling, with a 3-cycle latency check on the first beat.
        load_kernel(32'h01ffff01);
        send(32'h01ffff01, 1'b0, 1'b0, 32'h0, 8'h04, 1'b0, 8'h02);
        fork
            begin
                repeat (2) @(negedge clk);
                check_eq("lat_early", {31'd0, out_valid}, 32'd0);
                @(negedge clk);
                check_eq("lat3", {31'd0, out_valid}, 32'd1);
            end
            begin
                send(32'hff0101ff, 1'b0, 1'b0, 32'h0, 8'hfc, 1'b0, 8'hfe);
                send(32'h01010101, 1'b0, 1'b0, 32'h0, 8'h00, 1'b0, 8'h00);
                send(32'hffffffff, 1'b0, 1'b0, 32'h0, 8'h00, 1'b0, 8'h00);
            end
        join
        drain();

        // Kernel switch: same-cycle beat uses old weights.
        send(32'h01ffff01, 1'b0, 1'b1, 32'hff0101ff, 8'h04, 1'b0, 8'h02);
        send(32'h01ffff01, 1'b0, 1'b0, 32'h0, 8'hfc, 1'b0, 8'hfe);
        drain();

        // Saturation both directions.
        load_kernel(32'h7f7f7f7f);
        send(32'h7f7f7f7f, 1'b0, 1'b0, 32'h0, 8'h7f, 1'b1, 8'h7f);
        load_kernel(32'h80808080);
        send(32'h7f7f7f7f, 1'b0, 1'b0, 32'h0, 8'h80, 1'b1, 8'h80);
        drain();

        // ReLU is not saturation; shifted build checked on the second beat.
        load_kernel(32'h01ffff01);
        send(32'hff0101ff, 1'b1, 1'b0, 32'h0, 8'h00, 1'b0, 8'h00);
        send(32'h01ffff01, 1'b0, 1'b0, 32'h0, 8'h04, 1'b0, 8'h02);
        drain();

        // Backpressure with out_ready pattern 1,0,0,1,0,1 repeating.
        fork
            begin
                for (int c = 0; c < 40; c++) begin
                    out_ready = pat[c % 6];
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
            begin
                send(32'h01ffff01, 1'b0, 1'b0, 32'h0, 8'h04, 1'b0, 8'h02);
                send(32'hff0101ff, 1'b0, 1'b0, 32'h0, 8'hfc, 1'b0, 8'hfe);
                send(32'h01010101, 1'b0, 1'b0, 32'h0, 8'h00, 1'b0, 8'h00);
                send(32'h02fefe02, 1'b0, 1'b0, 32'h0, 8'h08, 1'b0, 8'h04);
                send(32'h03000000, 1'b0, 1'b0, 32'h0, 8'h03, 1'b0, 8'h01);
                send(32'h00000005, 1'b0, 1'b0, 32'h0, 8'h05, 1'b0, 8'h02);
            end
        join
        drain();

        // Reset with two beats in flight.
        send(32'h01ffff01, 1'b0, 1'b0, 32'h0, 8'h04, 1'b0, 8'h02);
        send(32'h01ffff01, 1'b0, 1'b0, 32'h0, 8'h04, 1'b0, 8'h02);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("midrst_conv", {24'd0, conv_result}, 32'd0);
        repeat (4) @(negedge clk);
        check_eq("midrst_no_stale", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        send(32'h01ffff01, 1'b0, 1'b0, 32'h0, 8'h00, 1'b0, 8'h00);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
